// File: rtl/dense_input_deserializer_pkg.sv
// Fixed-point conversion helpers and deserializer state type.
package fxp_pkg;

   typedef enum logic {FILL, FULL} deser_state_t;

   // Magnitude of the fractional-bit realignment between two Q formats.
   function automatic int shift_amt(input int in_nfrac, input int nfrac);
      return (nfrac >= in_nfrac) ? (nfrac - in_nfrac) : (in_nfrac - nfrac);
   endfunction

   // Intermediate width: wide enough that neither the shift nor the rounding add overflows.
   function automatic int conv_width(input int in_width, input int in_nfrac, input int nfrac);
      return in_width + shift_amt(in_nfrac, nfrac) + 1;
   endfunction

   // Round-half-up constant added before a right shift; zero when shifting left.
   function automatic longint round_const(input int in_nfrac, input int nfrac);
      return (nfrac >= in_nfrac) ? 64'sd0 : (64'sd1 <<< (in_nfrac - nfrac - 1));
   endfunction

   function automatic longint SAT_MAX(input int width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   function automatic longint SAT_MIN(input int width);
      return -(64'sd1 <<< (width - 1));
   endfunction

endpackage

// File: rtl/dense_input_deserializer_if.sv
// Sample-in / frame-out stream bundle for the dense layer input deserializer.
interface dense_input_deserializer_if #(
   parameter int IN_WIDTH   = 16,
   parameter int WIDTH      = 17,
   parameter int INPUT_SIZE = 32
);
   logic signed [IN_WIDTH-1:0] in_data;
   logic                       in_valid;
   logic                       in_last;
   logic                       in_ready;
   logic signed [WIDTH-1:0]    out_data [0:INPUT_SIZE-1];
   logic                       out_valid;
   logic                       out_ready;
   logic                       out_sat;
   logic                       frame_err;

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_valid, out_sat, frame_err
   );

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_valid, out_sat, frame_err
   );
endinterface

// File: rtl/dense_input_deserializer_fxp_convert.sv
// Combinational Q-format conversion with round-half-up and saturation.
module fxp_convert
   import fxp_pkg::*;
#(
   parameter int IN_WIDTH = 16,
   parameter int IN_NFRAC = 8,
   parameter int WIDTH    = 17,
   parameter int NFRAC    = 10
) (
   input  logic signed [IN_WIDTH-1:0] in,
   output logic signed [WIDTH-1:0]    out,
   output logic                       sat
);
   localparam int     SH   = shift_amt(IN_NFRAC, NFRAC);
   localparam int     IW   = conv_width(IN_WIDTH, IN_NFRAC, NFRAC);
   localparam longint MAXV = SAT_MAX(WIDTH);
   localparam longint MINV = SAT_MIN(WIDTH);
   localparam logic signed [WIDTH-1:0] OMAX = MAXV[WIDTH-1:0];
   localparam logic signed [WIDTH-1:0] OMIN = MINV[WIDTH-1:0];

   logic signed [IW-1:0] ext;
   logic signed [IW-1:0] wide;
   logic signed [63:0]   w64;

   assign ext = {{(IW-IN_WIDTH){in[IN_WIDTH-1]}}, in};

   generate
      if (NFRAC >= IN_NFRAC) begin : g_left
         assign wide = ext <<< SH;
      end else begin : g_right
         localparam logic signed [IW-1:0] RCV = IW'(round_const(IN_NFRAC, NFRAC));
         assign wide = (ext + RCV) >>> SH;
      end
   endgenerate

   assign w64 = {{(64-IW){wide[IW-1]}}, wide};

   // Clamp to the output range and flag when clamping happened.
   always_comb begin
      sat = 1'b0;
      out = w64[WIDTH-1:0];
      if (w64 > MAXV) begin
         sat = 1'b1;
         out = OMAX;
      end else if (w64 < MINV) begin
         sat = 1'b1;
         out = OMIN;
      end
   end
endmodule

// File: rtl/dense_input_deserializer.sv
// Serial-to-parallel front end: converts samples and gathers them into frames for the dense layer.
module dense_input_deserializer
   import fxp_pkg::*;
#(
   parameter int IN_WIDTH   = 16,
   parameter int IN_NFRAC   = 8,
   parameter int WIDTH      = 17,
   parameter int NFRAC      = 10,
   parameter int INPUT_SIZE = 32
) (
   input logic clk,
   input logic reset,
   dense_input_deserializer_if.slave bus
);
   localparam int CNT_W = $clog2(INPUT_SIZE);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(INPUT_SIZE - 1);

   deser_state_t            state;
   logic [CNT_W-1:0]        cnt;
   logic signed [WIDTH-1:0] cbuf [0:INPUT_SIZE-2];
   logic                    acc_sat;
   logic signed [WIDTH-1:0] last_el;
   logic                    last_sat;

   logic signed [WIDTH-1:0] conv;
   logic                    conv_sat;
   logic                    accept;
   logic                    slot_free;
   logic                    frame_sat;

   fxp_convert #(
      .IN_WIDTH (IN_WIDTH),
      .IN_NFRAC (IN_NFRAC),
      .WIDTH    (WIDTH),
      .NFRAC    (NFRAC)
   ) u_conv (
      .in  (bus.in_data),
      .out (conv),
      .sat (conv_sat)
   );

   assign accept    = bus.in_valid && bus.in_ready;
   assign slot_free = !bus.out_valid || bus.out_ready;
   // First element of a frame starts a fresh saturation accumulation.
   assign frame_sat = ((cnt == '0) ? 1'b0 : acc_sat) | conv_sat;

   // Frame FSM: collect into cbuf, hand off to the output register, stall in FULL when the slot is busy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= FILL;
         cnt           <= '0;
         acc_sat       <= 1'b0;
         last_el       <= '0;
         last_sat      <= 1'b0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.out_sat   <= 1'b0;
         bus.frame_err <= 1'b0;
         for (int unsigned i = 0; i < INPUT_SIZE - 1; i++) cbuf[i] <= '0;
         for (int unsigned i = 0; i < INPUT_SIZE; i++) bus.out_data[i] <= '0;
      end else begin
         bus.frame_err <= 1'b0;
         if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;

         case (state)
            FILL: begin
               if (accept) begin
                  if (cnt != LAST_IDX) begin
                     if (bus.in_last) begin
                        // Premature end of frame: drop what was gathered.
                        cnt           <= '0;
                        bus.frame_err <= 1'b1;
                     end else begin
                        cbuf[cnt] <= conv;
                        acc_sat   <= frame_sat;
                        cnt       <= cnt + 1'b1;
                     end
                  end else begin
                     bus.frame_err <= !bus.in_last;
                     if (slot_free) begin
                        for (int unsigned i = 0; i < INPUT_SIZE - 1; i++) bus.out_data[i] <= cbuf[i];
                        bus.out_data[INPUT_SIZE-1] <= conv;
                        bus.out_sat   <= frame_sat;
                        bus.out_valid <= 1'b1;
                        cnt           <= '0;
                     end else begin
                        last_el      <= conv;
                        last_sat     <= frame_sat;
                        state        <= FULL;
                        bus.in_ready <= 1'b0;
                     end
                  end
               end
            end
            FULL: begin
               if (slot_free) begin
                  for (int unsigned i = 0; i < INPUT_SIZE - 1; i++) bus.out_data[i] <= cbuf[i];
                  bus.out_data[INPUT_SIZE-1] <= last_el;
                  bus.out_sat   <= last_sat;
                  bus.out_valid <= 1'b1;
                  cnt           <= '0;
                  state         <= FILL;
                  bus.in_ready  <= 1'b1;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dense_input_deserializer.sv
// Directed bench for dense_input_deserializer (INPUT_SIZE=4, Q8.8 in, Q7.10 out).
module tb_dense_input_deserializer;
   localparam int N = 4;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic signed [16:0] exp_f [0:N-1];

   always #5 clk = ~clk;

   dense_input_deserializer_if #(.IN_WIDTH(16), .WIDTH(17), .INPUT_SIZE(N)) bus ();

   dense_input_deserializer #(
      .IN_WIDTH   (16),
      .IN_NFRAC   (8),
      .WIDTH      (17),
      .NFRAC      (10),
      .INPUT_SIZE (N)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Present one sample (called at a negedge), wait for acceptance, return at the next negedge.
   task automatic push(input logic [15:0] d, input logic last);
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      bus.in_last  = last;
      for (int k = 0; k < 50 && bus.in_ready !== 1'b1; k++) @(negedge clk);
      if (bus.in_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL push_timeout in_ready=%b required 1", bus.in_ready);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL consume_valid got %b want 0", bus.out_valid);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
      checks++;
      if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL rst_out_sat got %b want 0", bus.out_sat); end
      checks++;
      if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err got %b want 0", bus.frame_err); end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (bus.out_data[i] !== 17'sd0) begin
            errors++;
            $display("FAIL rst_data[%0d] got %0d want 0", i, bus.out_data[i]);
         end
      end
   endtask

   task automatic test_conversion();
      exp_f = '{17'sd1024, -17'sd4, 17'sd512, -17'sd1024};
      push(16'h0100, 1'b0);
      push(16'hFFFF, 1'b0);
      push(16'h0080, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL conv_early_valid got %b want 0", bus.out_valid); end
      push(16'hFF00, 1'b1);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL conv_valid got %b want 1", bus.out_valid); end
      checks++;
      if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL conv_sat got %b want 0", bus.out_sat); end
      checks++;
      if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL conv_frame_err got %b want 0", bus.frame_err); end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (bus.out_data[i] !== exp_f[i]) begin
            errors++;
            $display("FAIL conv_data[%0d] got %0d want %0d", i, bus.out_data[i], exp_f[i]);
         end
      end
      consume();
   endtask

   task automatic test_saturation();
      exp_f = '{17'sd65535, -17'sd65536, 17'sd0, 17'sd1024};
      push(16'h7FFF, 1'b0);
      push(16'h8000, 1'b0);
      push(16'h0000, 1'b0);
      push(16'h0100, 1'b1);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      checks++;
      if (bus.out_sat !== 1'b1) begin errors++; $display("FAIL sat_flag got %b want 1", bus.out_sat); end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (bus.out_data[i] !== exp_f[i]) begin
            errors++;
            $display("FAIL sat_data[%0d] got %0d want %0d", i, bus.out_data[i], exp_f[i]);
         end
      end
      consume();
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b1;
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < N; i++) begin
            exp_f[i] = 17'((f * N + i + 1) * 64);
            push(16'((f * N + i + 1) * 16), (i == N - 1));
            checks++;
            if (bus.in_ready !== 1'b1) begin
               errors++;
               $display("FAIL b2b_in_ready f%0d s%0d got %b want 1", f, i, bus.in_ready);
            end
            checks++;
            if (bus.out_valid !== (i == N - 1)) begin
               errors++;
               $display("FAIL b2b_valid f%0d s%0d got %b want %b", f, i, bus.out_valid, (i == N - 1));
            end
         end
         for (int i = 0; i < N; i++) begin
            checks++;
            if (bus.out_data[i] !== exp_f[i]) begin
               errors++;
               $display("FAIL b2b_data f%0d [%0d] got %0d want %0d", f, i, bus.out_data[i], exp_f[i]);
            end
         end
      end
      idle();
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
      bus.out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      for (int i = 0; i < N; i++) push(16'((i + 1) * 256), (i == N - 1));
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_f1_valid got %b want 1", bus.out_valid); end
      for (int i = 0; i < N; i++) push(16'((i + 5) * 256), (i == N - 1));
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_fall got %b want 0", bus.in_ready); end
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_hold c%0d got %b want 0", c, bus.in_ready); end
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (bus.out_data[i] !== 17'((i + 1) * 1024)) begin
            errors++;
            $display("FAIL bp_f1_stable[%0d] got %0d want %0d", i, bus.out_data[i], (i + 1) * 1024);
         end
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_f2_valid got %b want 1", bus.out_valid); end
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_rise got %b want 1", bus.in_ready); end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (bus.out_data[i] !== 17'((i + 5) * 1024)) begin
            errors++;
            $display("FAIL bp_f2_data[%0d] got %0d want %0d", i, bus.out_data[i], (i + 5) * 1024);
         end
      end
      consume();
   endtask

   task automatic test_early_last();
      bus.out_ready = 1'b0;
      push(16'h0100, 1'b0);
      push(16'h0200, 1'b1);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      checks++;
      if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL early_err got %b want 1", bus.frame_err); end
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL early_valid got %b want 0", bus.out_valid); end
      idle();
      checks++;
      if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL early_err_pulse got %b want 0", bus.frame_err); end
      exp_f = '{17'sd3072, 17'sd4096, 17'sd5120, 17'sd6144};
      push(16'h0300, 1'b0);
      push(16'h0400, 1'b0);
      push(16'h0500, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL early_next_premature got %b want 0", bus.out_valid); end
      push(16'h0600, 1'b1);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL early_next_valid got %b want 1", bus.out_valid); end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (bus.out_data[i] !== exp_f[i]) begin
            errors++;
            $display("FAIL early_next_data[%0d] got %0d want %0d", i, bus.out_data[i], exp_f[i]);
         end
      end
      consume();
   endtask

   task automatic test_missing_last();
      for (int i = 0; i < N; i++) push(16'h0040, 1'b0);
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL nolast_valid got %b want 1", bus.out_valid); end
      checks++;
      if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL nolast_err got %b want 1", bus.frame_err); end
      checks++;
      if (bus.out_data[N-1] !== 17'sd256) begin errors++; $display("FAIL nolast_data got %0d want 256", bus.out_data[N-1]); end
      consume();
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 1'b0;
      push(16'h7FFF, 1'b0);
      push(16'h0000, 1'b0);
      push(16'h0000, 1'b0);
      push(16'h0000, 1'b1);
      push(16'h0100, 1'b0);
      push(16'h0200, 1'b0);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got %b want 1", bus.out_valid); end
      reset = 1'b1;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", bus.out_valid); end
      checks++;
      if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL rmid_sat got %b want 0", bus.out_sat); end
      checks++;
      if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b want 1", bus.in_ready); end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (bus.out_data[i] !== 17'sd0) begin
            errors++;
            $display("FAIL rmid_data[%0d] got %0d want 0", i, bus.out_data[i]);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      exp_f = '{17'sd64, 17'sd128, 17'sd192, 17'sd256};
      push(16'h0010, 1'b0);
      push(16'h0020, 1'b0);
      push(16'h0030, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_premature got %b want 0", bus.out_valid); end
      push(16'h0040, 1'b1);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rmid_next_valid got %b want 1", bus.out_valid); end
      checks++;
      if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL rmid_next_sat got %b want 0", bus.out_sat); end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (bus.out_data[i] !== exp_f[i]) begin
            errors++;
            $display("FAIL rmid_next_data[%0d] got %0d want %0d", i, bus.out_data[i], exp_f[i]);
         end
      end
      consume();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      reset         = 1'b1;
      bus.in_data   = '0;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      reset = 1'b0;
      @(negedge clk);
      test_conversion();
      test_saturation();
      test_back_to_back();
      test_backpressure();
      test_early_last();
      test_missing_last();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
